// File: rtl/ahb_lite_adc_bridge.sv
// rtl/ahb_lite_adc_bridge.sv - AHB-Lite slave to ADC register-port bridge; optional ADC_BRIDGE_ERROR_RESP_EN.
// A read issued right behind a posted write stalls two cycles so it observes the written value.
module ahb_lite_adc_bridge #(
    parameter int ADDR_W    = 4,
    parameter int REG_LIMIT = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HADDR,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [31:0]       read_data,
    output logic [ADDR_W-1:0] write_addr,
    output logic [31:0]       write_data,
    output logic              write_enable
);

    typedef enum logic [2:0] {
        IDLE, RD_DATA, WR_DATA, RD_STALL1, RD_STALL2, ERR1, ERR2
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] haddr_word;
    logic              in_range_q;
    logic              haddr_in_range;
    logic              accept;
    logic              bad_xfer;
    logic              unused_bits;

    assign haddr_word     = HADDR[ADDR_W+1:2];
    assign haddr_in_range = ({{(32-ADDR_W){1'b0}}, haddr_word} < 32'(REG_LIMIT));
    assign unused_bits    = ^{HADDR[31:ADDR_W+2], HADDR[1:0], HSIZE, HTRANS[0]};

    // HREADYOUT is folded in so nothing is accepted while this slave stalls.
    assign accept = HSEL & HREADY & HTRANS[1] & HREADYOUT;

`ifdef ADC_BRIDGE_ERROR_RESP_EN
    assign bad_xfer = (HSIZE != 3'b010) || (HADDR[1:0] != 2'b00) || !haddr_in_range;
    assign HRESP    = (state == ERR1) || (state == ERR2);
`else
    assign bad_xfer = 1'b0;
    assign HRESP    = 1'b0;
`endif

    assign HREADYOUT = !((state == RD_STALL1) || (state == RD_STALL2) || (state == ERR1));
    assign read_addr = ((state == RD_STALL1) || (state == RD_STALL2)) ? addr_q : haddr_word;
    assign HRDATA    = ((state == RD_DATA) && in_range_q) ? read_data : 32'h0;

    always_comb begin
        state_nxt = state;
        case (state)
            RD_STALL1: state_nxt = RD_STALL2;
            RD_STALL2: state_nxt = RD_DATA;
            ERR1:      state_nxt = ERR2;
            default: begin
                state_nxt = IDLE;
                if (accept) begin
                    if (bad_xfer)
                        state_nxt = ERR1;
                    else if (HWRITE)
                        state_nxt = WR_DATA;
                    else if (state == WR_DATA)
                        state_nxt = RD_STALL1;
                    else
                        state_nxt = RD_DATA;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state        <= IDLE;
            addr_q       <= '0;
            in_range_q   <= 1'b0;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q     <= haddr_word;
                in_range_q <= haddr_in_range;
            end
            // Posted write: strobe in the cycle after the data phase; out-of-range words are dropped.
            write_enable <= (state == WR_DATA) && in_range_q;
            if (state == WR_DATA) begin
                write_addr <= addr_q;
                write_data <= HWDATA;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_adc_bridge.sv
// tb/tb_ahb_lite_adc_bridge.sv - self-checking bench for ahb_lite_adc_bridge (table, corner sequence, random).
module tb_ahb_lite_adc_bridge;

    localparam int ADDR_W = 4;
    localparam int LIMIT  = 12;
`ifdef ADC_BRIDGE_ERROR_RESP_EN
    localparam int          ERR_W   = 1;
    localparam logic [31:0] BYTE_RD = 32'h0000000B;
`else
    localparam int          ERR_W   = 0;
    localparam logic [31:0] BYTE_RD = 32'h00000055;
`endif

    logic              HCLK    = 1'b0;
    logic              HRESETn = 1'b1;
    logic              HSEL    = 1'b0;
    logic [1:0]        HTRANS  = 2'b00;
    logic              HWRITE  = 1'b0;
    logic [2:0]        HSIZE   = 3'b010;
    logic [31:0]       HADDR   = 32'h0;
    logic [31:0]       HWDATA  = 32'h0;
    logic              HREADY;
    logic [31:0]       HRDATA;
    logic              HREADYOUT;
    logic              HRESP;
    logic [ADDR_W-1:0] read_addr;
    logic [31:0]       read_data;
    logic [ADDR_W-1:0] write_addr;
    logic [31:0]       write_data;
    logic              write_enable;

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    ahb_lite_adc_bridge #(.ADDR_W(ADDR_W), .REG_LIMIT(LIMIT)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HADDR(HADDR), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .read_addr(read_addr), .read_data(read_data),
        .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable)
    );

    // Register-file core: registered read, a same-edge write is visible to the read.
    logic [31:0] core_mem [16];
    logic        core_ready = 1'b0;
    always @(posedge HCLK) begin
        if (!core_ready) begin
            for (int k = 0; k < 16; k++) core_mem[k] <= 32'hA000_0000 + 32'(k);
            core_ready <= 1'b1;
            read_data  <= 32'h0;
        end else begin
            if (write_enable) core_mem[write_addr] <= write_data;
            read_data <= (write_enable && write_addr == read_addr) ? write_data : core_mem[read_addr];
        end
    end

    typedef struct {
        int          kind;      // 0 no transfer, 1 write, 2 read
        logic        hsel;
        logic [1:0]  htrans;
        logic [3:0]  idx;
        logic [31:0] data;
        logic [2:0]  size;
        logic        has_exp;
        int          exp_waits;
        logic [31:0] exp_rdata;
    } op_t;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
        int          c;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;
    op_t         prog[$];
    wr_t         exp_wr[$];
    wr_t         mon_e;
    logic [31:0] model_mem [16];

    always @(posedge HCLK) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge HCLK) begin
        if (HRESETn && write_enable) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected actual=addr %h data %h required=no pulse", write_addr, write_data);
            end else begin
                mon_e = exp_wr.pop_front();
                check("wr_addr", 32'(write_addr), 32'(mon_e.a));
                check("wr_data", write_data, mon_e.d);
                check("wr_cycle", cyc_cnt, mon_e.c);
            end
        end
    end

    function automatic op_t mk(int kind, logic [3:0] idx, logic [31:0] data, logic [2:0] size,
                               logic has, int w, logic [31:0] rd);
        op_t o;
        o.kind = kind; o.hsel = (kind != 0); o.htrans = (kind != 0) ? 2'b10 : 2'b00;
        o.idx = idx; o.data = data; o.size = size;
        o.has_exp = has; o.exp_waits = w; o.exp_rdata = rd;
        return o;
    endfunction

    function automatic logic is_err(op_t o);
`ifdef ADC_BRIDGE_ERROR_RESP_EN
        return (o.size != 3'b010) || (int'(o.idx) >= LIMIT);
`else
        return 1'b0;
`endif
    endfunction

    task automatic run_prog();
        int i = 0, waits = 0, exp_waits = 0, guard = 0;
        op_t cur, dp;
        logic dp_valid = 1'b0, dp_err = 1'b0, prev_wr, ready;
        logic [31:0] exp_rd;
        while ((i < prog.size() || dp_valid) && guard < 5000) begin
            guard++;
            if (i < prog.size()) begin
                cur    = prog[i];
                HSEL   = cur.hsel;
                HTRANS = cur.htrans;
                HWRITE = (cur.kind == 1);
                HSIZE  = cur.size;
                HADDR  = {26'h0, cur.idx, 2'b00};
            end else begin
                HSEL = 1'b0; HTRANS = 2'b00;
            end
            HWDATA = (dp_valid && dp.kind == 1) ? dp.data : 32'h0;
            @(negedge HCLK);
            ready   = HREADYOUT;
            prev_wr = 1'b0;
            if (dp_valid) begin
                if (!ready) begin
                    waits++;
                    if (waits > 8) begin
                        check("stall_timeout", 32'(waits), 32'(exp_waits));
                        dp_valid = 1'b0;
                    end
                end else begin
                    check("waits", 32'(waits), 32'(exp_waits));
                    check("hresp", 32'(HRESP), 32'(dp_err));
                    if (dp.kind == 2) begin
                        exp_rd = (!dp_err && int'(dp.idx) < LIMIT) ? model_mem[dp.idx] : 32'h0;
                        check("rdata", HRDATA, exp_rd);
                    end else begin
                        check("wr_phase_rdata", HRDATA, 32'h0);
                        if (!dp_err && int'(dp.idx) < LIMIT) begin
                            exp_wr.push_back('{dp.idx, dp.data, cyc_cnt + 1});
                            model_mem[dp.idx] = dp.data;
                        end
                    end
                    if (dp.has_exp) begin
                        check("tbl_waits", 32'(waits), 32'(dp.exp_waits));
                        if (dp.kind == 2) check("tbl_rdata", HRDATA, dp.exp_rdata);
                    end
                    prev_wr  = (dp.kind == 1) && !dp_err;
                    dp_valid = 1'b0;
                end
            end else begin
                check("idle_ready", 32'(HREADYOUT), 32'd1);
                check("idle_rdata", HRDATA, 32'h0);
                check("idle_resp", 32'(HRESP), 32'd0);
            end
            if (ready && i < prog.size()) begin
                if (cur.kind != 0) begin
                    dp = cur; dp_valid = 1'b1; waits = 0; dp_err = is_err(cur);
                    exp_waits = dp_err ? 1 : (cur.kind == 2 && prev_wr) ? 2 : 0;
                end
                i++;
            end
            @(posedge HCLK);
            #1;
        end
        if (guard >= 5000) check("prog_timeout", 32'(guard), 32'd0);
        HSEL = 1'b0; HTRANS = 2'b00;
    endtask

    initial begin
        op_t tbl[$];
        op_t busy;
        tbl.push_back(mk(0, 0, 0, 3'b010, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h4, 3'b010, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'b010, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'b010, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'hB, 3'b010, 1, 0, 0));
        tbl.push_back(mk(2, 0, 0, 3'b010, 1, 2, 32'hB));
        tbl.push_back(mk(0, 0, 0, 3'b010, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h1, 3'b010, 1, 0, 0));
        tbl.push_back(mk(1, 2, 32'h2, 3'b010, 1, 0, 0));
        tbl.push_back(mk(1, 3, 32'h3, 3'b010, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'b010, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'b010, 0, 0, 0));
        tbl.push_back(mk(2, 0, 0, 3'b010, 1, 0, 32'hB));
        tbl.push_back(mk(2, 5, 0, 3'b010, 1, 0, 32'hA000_0005));
        tbl.push_back(mk(2, 13, 0, 3'b010, 1, ERR_W, 32'h0));
        tbl.push_back(mk(1, 13, 32'hDEAD_BEEF, 3'b010, 1, ERR_W, 0));
        tbl.push_back(mk(0, 0, 0, 3'b010, 0, 0, 0));
        tbl.push_back(mk(2, 13, 0, 3'b010, 1, ERR_W, 32'h0));
        tbl.push_back(mk(1, 0, 32'h55, 3'b000, 1, ERR_W, 0));
        busy = mk(0, 0, 0, 3'b010, 0, 0, 0);
        busy.hsel = 1'b1; busy.htrans = 2'b01;
        tbl.push_back(busy);
        tbl.push_back(mk(2, 0, 0, 3'b010, 1, 0, BYTE_RD));

        for (int k = 0; k < 16; k++) model_mem[k] = 32'hA000_0000 + 32'(k);

        #2 HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_ready", 32'(HREADYOUT), 32'd1);
        check("rst_resp", 32'(HRESP), 32'd0);
        check("rst_rdata", HRDATA, 32'h0);
        check("rst_we", 32'(write_enable), 32'd0);
        check("rst_waddr", 32'(write_addr), 32'd0);
        check("rst_wdata", write_data, 32'h0);
        @(posedge HCLK);
        #1 HRESETn = 1'b1;

        for (int k = 0; k < tbl.size(); k++) prog.push_back(tbl[k]);
        run_prog();

        // Reset lands in the cycle the posted write strobes: the write must vanish.
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'b010; HADDR = 32'h8;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h77;
        @(posedge HCLK); #1;
        check("pre_rst_we", 32'(write_enable), 32'd1);
        HRESETn = 1'b0;
        #1;
        check("rst2_we", 32'(write_enable), 32'd0);
        check("rst2_ready", 32'(HREADYOUT), 32'd1);
        check("rst2_waddr", 32'(write_addr), 32'd0);
        check("rst2_rdata", HRDATA, 32'h0);
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        prog.delete();
        prog.push_back(mk(2, 2, 0, 3'b010, 1, 0, 32'h2));
        for (int k = 0; k < 400; k++) begin
            op_t r;
            r = mk($urandom_range(0, 2), 4'($urandom_range(0, 15)), $urandom, 3'b010, 0, 0, 0);
            if (r.kind == 0) begin
                r.hsel   = 1'($urandom_range(0, 1));
                r.htrans = 2'($urandom_range(0, 1));
            end
            prog.push_back(r);
        end
        run_prog();

        repeat (4) @(negedge HCLK);
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_lite_adc_bridge.md
AHB_LITE_ADC_BRIDGE -- requirements
Module: ahb_lite_adc_bridge

Interface
REQ-001 Parameter ADDR_W, default 4, width of the register word address (matches ADC_ADDR_WIDTH).
REQ-002 Parameter REG_LIMIT, default 16, number of implemented register words; valid word indices are 0..REG_LIMIT-1.
REQ-003 HCLK  in  1  single clock for the bridge and the register side.
REQ-004 HRESETn  in  1  reset, asynchronous, active-low.
REQ-005 HSEL, HTRANS[1:0], HWRITE, HSIZE[2:0], HADDR[31:0], HWDATA[31:0], HREADY  in  AHB-Lite slave inputs, standard meaning.
REQ-006 HRDATA[31:0], HREADYOUT, HRESP  out  AHB-Lite slave outputs.
REQ-007 read_addr  out  ADDR_W  register read word address; core returns read_data one HCLK after read_addr.
REQ-008 read_data  in  32  registered read data from the ADC core.
REQ-009 write_addr  out  ADDR_W, write_data  out  32, write_enable  out  1: single-cycle register write strobe.

Function
REQ-010 Transfer accepted when HSEL & HREADY & HTRANS[1] at a rising HCLK edge; HADDR[ADDR_W+1:2], HWRITE, HSIZE are latched then.
REQ-011 FSM states: IDLE, RD_DATA, WR_DATA, RD_STALL1, RD_STALL2, ERR1, ERR2.
REQ-012 IDLE/RD_DATA/WR_DATA: a new accepted transfer moves to RD_DATA (read) or WR_DATA (write); no transfer returns to IDLE.
REQ-013 Write: HWDATA captured at the end of the WR_DATA cycle; write_enable=1 for exactly the following cycle with the latched address and captured data (posted write, one-entry buffer).
REQ-014 Back-to-back writes sustain one write per cycle with zero wait states; each write_enable pulse carries its own address/data, in order.
REQ-015 read_addr = HADDR[ADDR_W+1:2] combinationally in IDLE/RD_DATA/WR_DATA; read_addr = latched read address in RD_STALL1/RD_STALL2.
REQ-016 Read not preceded by a WR_DATA cycle: RD_DATA has HREADYOUT=1, HRDATA=read_data, zero wait states.
REQ-017 Read whose address phase is accepted during a WR_DATA cycle (any address): RD_STALL1 and RD_STALL2 each drive HREADYOUT=0, then RD_DATA returns read_data with HREADYOUT=1 (exactly 2 wait states, post-write value).
REQ-018 While stalled (HREADYOUT=0), no new transfer is accepted and the pending write still commits on schedule.
REQ-019 HRDATA = 0 in every state except RD_DATA; HRESP=0 (OKAY) outside ERR1/ERR2.
REQ-020 HTRANS IDLE/BUSY with HSEL=1 gets a zero-wait OKAY response; no register access.
REQ-021 Words with index >= REG_LIMIT read as 0 and are never written (when REQ-026 is not compiled in).

Reset
REQ-022 HRESETn low asynchronously forces: state IDLE, write_enable=0, write_addr=0, write_data=0, HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-023 Reset during a pending write or stall discards it: no write_enable pulse after reset release, bus restarts in IDLE.
REQ-024 First transfer may be accepted on the first HCLK edge after HRESETn deasserts.

Configuration
REQ-025 Macro ADC_BRIDGE_ERROR_RESP_EN selects bus-error reporting.
REQ-026 Defined: accepted transfer with HSIZE!=3'b010, HADDR[1:0]!=0, or word index >= REG_LIMIT enters ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); no write_enable, HRDATA=0; then IDLE or next accepted transfer.
REQ-027 Undefined: ERR1/ERR2 unreachable, HRESP tied 0, all transfers treated as word accesses on HADDR[ADDR_W+1:2].

Verification
REQ-028 Write 0x4 to ADMSK (word 1) -> write_enable=1 exactly one cycle after data phase, write_addr=1, write_data=0x00000004.
REQ-029 Write ADCS=0x0000000B then immediate read ADCS -> exactly 2 wait states, HRDATA=0x0000000B.
REQ-030 Three back-to-back writes to words 1,2,3 (data 0x1,0x2,0x3) -> three consecutive write_enable cycles, same order, no HREADYOUT=0.
REQ-031 Read word 0 after idle cycles -> zero wait states, HRDATA equals core read_data.
REQ-032 With ADC_BRIDGE_ERROR_RESP_EN: byte write (HSIZE=0) to word 0 -> ERR1/ERR2 two-cycle ERROR, write_enable stays 0; without macro: OKAY and write_enable pulses.
REQ-033 HRESETn asserted in the cycle after a write data phase -> write_enable=0 immediately, no pulse after release, HREADYOUT=1.
